// File: rtl/compare_unit_if.sv
// Operand/result handshake bundle for compare_unit.
// master = operand producer and result consumer; slave = the comparator.
interface compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             ne;
  logic             eq;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, ne, eq, lt, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, ne, eq, lt, busy
  );
endinterface

// File: rtl/compare_unit.sv
// Multi-cycle comparator: scans CHUNK bits per cycle, MS chunk first, stops on first difference.
// Optional macro SIGNED_LT_EN enables the signed less-than flag; otherwise lt is tied low.
module compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  compare_unit_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic             ne_q, eq_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] ca, cb;

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign ca = a_chunk[idx_q];
  assign cb = b_chunk[idx_q];

`ifdef SIGNED_LT_EN
  logic lt_q;
  logic lt_chunk;
  // Only the top chunk carries the sign; lower chunks are plain magnitude digits.
  assign lt_chunk = (idx_q == IDX_TOP) ? ($signed(ca) < $signed(cb)) : (ca < cb);
  assign bus.lt   = lt_q;
`else
  assign bus.lt   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= IDX_TOP;
      a_q         <= '0;
      b_q         <= '0;
      ne_q        <= 1'b0;
      eq_q        <= 1'b0;
`ifdef SIGNED_LT_EN
      lt_q        <= 1'b0;
`endif
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            ne_q       <= 1'b0;
            eq_q       <= 1'b0;
`ifdef SIGNED_LT_EN
            lt_q       <= 1'b0;
`endif
            idx_q      <= IDX_TOP;
            state_q    <= SCAN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (ca != cb) begin
            ne_q        <= 1'b1;
            eq_q        <= 1'b0;
`ifdef SIGNED_LT_EN
            lt_q        <= lt_chunk;
`endif
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else if (idx_q == '0) begin
            ne_q        <= 1'b0;
            eq_q        <= 1'b1;
`ifdef SIGNED_LT_EN
            lt_q        <= 1'b0;
`endif
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          // Flags deliberately survive the handshake until the next acceptance.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ne        = ne_q;
  assign bus.eq        = eq_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_compare_unit.sv
// Randomized self-checking bench for compare_unit against a whole-operand reference model.
module tb_compare_unit;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  compare_unit_if #(.WIDTH(WIDTH)) bus();

  compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Chunks scanned = position of the highest differing bit, counted in chunks from the top.
  function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (x[i]) return NCHUNK - i / CHUNK;
    return NCHUNK;
  endfunction

  function automatic logic exp_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SIGNED_LT_EN
    return $signed(a) < $signed(b);
`else
    return 1'b0;
`endif
  endfunction

  // hold == 0: out_ready high throughout; hold > 0: backpressure for hold cycles in DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int   lat;
    int   k;
    logic e_ne, e_eq, e_lt;
    e_ne = (a != b);
    e_eq = (a == b);
    e_lt = exp_lt(a, b);
    k    = exp_latency(a, b);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    check("in_ready_scan", 32'(bus.in_ready), 32'd0);
    check("busy_scan", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 3 * NCHUNK) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, k);
    check("ne", 32'(bus.ne), 32'(e_ne));
    check("eq", 32'(bus.eq), 32'(e_eq));
    check("lt", 32'(bus.lt), 32'(e_lt));
    $display("[TB] op a=%h b=%h hold=%0d ne=%0d eq=%0d lt=%0d lat=%0d", a, b, hold,
             bus.ne, bus.eq, bus.lt, lat);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_ne", 32'(bus.ne), 32'(e_ne));
      check("hold_lt", 32'(bus.lt), 32'(e_lt));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (hold > 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    check("consumed_valid", 32'(bus.out_valid), 32'd0);
    check("consumed_in_ready", 32'(bus.in_ready), 32'd1);
    check("consumed_busy", 32'(bus.busy), 32'd0);
    check("flags_persist", 32'({bus.ne, bus.eq}), 32'({e_ne, e_eq}));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sel;
    int c;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", 32'({bus.ne, bus.eq, bus.lt}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    run_op(32'h1234_5678, 32'h1234_5678, 0);
    run_op(32'h8000_0000, 32'h0000_0000, 0);
    run_op(32'h0000_0001, 32'h0000_0002, 0);
    run_op(32'h0000_0002, 32'h0000_0001, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 5);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Reset in the middle of a scan discards the operation.
    bus.out_ready = 1'b0;
    bus.a         = 32'hFFFF_FFFF;
    bus.b         = 32'hFFFF_FFFF;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(32'h0000_0003, 32'h0000_0003, 0);

    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0: rb = ra;
        1: rb = $urandom;
        2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: begin
          c  = $urandom_range(0, NCHUNK - 1);
          rb = ra;
          rb[c*CHUNK +: CHUNK] = 8'($urandom);
        end
      endcase
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
